isr_loader_mem: RTL

//  Parametrised program/data memory with a built-in bench loader.

---
 rtl/isr_loader_mem.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/isr_loader_mem.sv
// Program/data memory with a built-in streaming loader that releases the CPU port once a session ends.
// Latency: loader and CPU writes land at the clock edge; CPU reads return one cycle after the request.
// Backpressure: o_ld_ready is high only while loading; the CPU is stalled through o_cpu_hold outside RUN.
module isr_loader_mem #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 12,
    parameter int DEPTH     = 4096,
    parameter int BASE_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ld_start,
    input  logic              i_ld_valid,
    input  logic [DATA_W-1:0] i_ld_data,
    input  logic              i_ld_last,
    output logic              o_ld_ready,
    output logic              o_ld_done,
    output logic [ADDR_W:0]   o_ld_count,
    output logic              o_ld_ovf,
    output logic              o_cpu_hold,
    input  logic              i_cpu_en,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_rvalid,
    output logic              o_cpu_err
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] BASE_C  = (ADDR_W+1)'(BASE_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_ERR} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W:0]   r_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_ovf;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;
    logic              r_err;

    logic              w_ld_fire;
    logic              w_ptr_ok;
    logic              w_cpu_fire;
    logic              w_cpu_ok;
    logic              w_mem_we;
    logic [IDX_W-1:0]  w_mem_idx;
    logic [DATA_W-1:0] w_mem_wdat;
    logic [IDX_W-1:0]  w_cpu_idx;

    // A start pulse owns its cycle: any word presented alongside it is not a handshake.
    assign w_ld_fire  = (r_state == S_LOAD) && i_ld_valid && !i_ld_start;
    // ptr is one bit wider than the address so it can reach DEPTH without wrapping.
    assign w_ptr_ok   = (r_ptr < DEPTH_C);
    assign w_cpu_fire = (r_state == S_RUN) && i_cpu_en;
    assign w_cpu_ok   = ({1'b0, i_cpu_addr} < DEPTH_C);
    assign w_cpu_idx  = i_cpu_addr[IDX_W-1:0];

    // State register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: start from anywhere, finish on last word, trap on overflow
    always_comb begin
        w_next = r_state;
        if (i_ld_start) begin
            w_next = S_LOAD;
        end else if (w_ld_fire) begin
            if (!w_ptr_ok) begin
                w_next = S_ERR;
            end else if (i_ld_last) begin
                w_next = S_RUN;
            end
        end
    end

    // Outputs decoded from the registered state only
    always_comb begin
        o_ld_ready = (r_state == S_LOAD);
        o_ld_done  = (r_state == S_RUN);
        o_cpu_hold = (r_state != S_RUN);
    end

    // Load pointer, session word count and sticky overflow flag
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_ptr   <= BASE_C;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (i_ld_start) begin
            r_ptr   <= BASE_C;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_ld_fire) begin
            if (w_ptr_ok) begin
                r_ptr   <= r_ptr + 1'b1;
                r_count <= r_count + 1'b1;
            end else begin
                r_ovf   <= 1'b1;
            end
        end
    end

    // Single write port shared by loader (LOAD) and CPU (RUN); the states never overlap
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_idx  = '0;
        w_mem_wdat = '0;
        if (w_ld_fire && w_ptr_ok) begin
            w_mem_we   = 1'b1;
            w_mem_idx  = r_ptr[IDX_W-1:0];
            w_mem_wdat = i_ld_data;
        end else if (w_cpu_fire && i_cpu_we && w_cpu_ok) begin
            w_mem_we   = 1'b1;
            w_mem_idx  = w_cpu_idx;
            w_mem_wdat = i_cpu_wdata;
        end
    end

    // Storage array: deliberately outside reset so contents survive it
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdat;
        end
    end

    // CPU response pipeline: registered read data, valid and range-error pulse
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_cpu_fire && !i_cpu_we;
            r_err    <= w_cpu_fire && !w_cpu_ok;
            if (w_cpu_fire && !i_cpu_we) begin
                r_rdata <= w_cpu_ok ? r_mem[w_cpu_idx] : '0;
            end
        end
    end

    assign o_ld_count   = r_count;
    assign o_ld_ovf     = r_ovf;
    assign o_cpu_rdata  = r_rdata;
    assign o_cpu_rvalid = r_rvalid;
    assign o_cpu_err    = r_err;

endmodule
